// File: rtl/axi_mul_pkg.sv
// Shared definitions for the AXI multiplier master and its slave peripheral:
// sequencer states, register offsets and the response-error rule.
package axi_mul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_RD_RES,
    ST_RD_OVF,
    ST_RESP
  } state_t;

  localparam int unsigned OFF_A   = 32'h10;
  localparam int unsigned OFF_B   = 32'h14;
  localparam int unsigned OFF_RES = 32'h18;
  localparam int unsigned OFF_OVF = 32'h1C;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_mul_master.sv
// AXI4-Lite master that writes two operands to a multiplier peripheral,
// reads back the product low word and overflow flag, and returns them.
module axi_mul_master
  import axi_mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_result,
  output logic                    rsp_ovf,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_A   = ADDR_WIDTH'(BASE_ADDR + OFF_A);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B   = ADDR_WIDTH'(BASE_ADDR + OFF_B);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RES = ADDR_WIDTH'(BASE_ADDR + OFF_RES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OVF = ADDR_WIDTH'(BASE_ADDR + OFF_OVF);

  state_t                  state, next_state;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  logic                    aw_done, w_done, ar_done;
  logic                    cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;

  assign cmd_fire = cmd_valid     & cmd_ready;
  assign aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_fire   = m_axi_wvalid  & m_axi_wready;
  assign b_fire   = m_axi_bvalid  & m_axi_bready;
  assign ar_fire  = m_axi_arvalid & m_axi_arready;
  assign r_fire   = m_axi_rvalid  & m_axi_rready;

  // Channel valids/readies derive from state plus per-phase done flags, so
  // AW and W retire independently and B/R are only accepted when expected.
  always_comb begin
    next_state    = state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_axi_awaddr  = ADDR_A;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = a_reg;
    m_axi_wstrb   = '1;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_araddr  = ADDR_RES;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = m_axi_aresetn;
        if (cmd_valid && m_axi_aresetn) next_state = ST_WR_A;
      end
      ST_WR_A, ST_WR_B: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        m_axi_bready  = aw_done && w_done;
        if (state == ST_WR_B) begin
          m_axi_awaddr = ADDR_B;
          m_axi_wdata  = b_reg;
        end
        if (b_fire) next_state = (state == ST_WR_A) ? ST_WR_B : ST_RD_RES;
      end
      ST_RD_RES, ST_RD_OVF: begin
        m_axi_arvalid = !ar_done;
        m_axi_rready  = ar_done;
        if (state == ST_RD_OVF) m_axi_araddr = ADDR_OVF;
        if (r_fire) next_state = (state == ST_RD_RES) ? ST_RD_OVF : ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state      <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      ar_done    <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= next_state;
      if (cmd_fire) begin
        a_reg   <= cmd_a;
        b_reg   <= cmd_b;
        rsp_err <= 1'b0;
      end
      if (b_fire) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (r_fire)       ar_done <= 1'b0;
      else if (ar_fire) ar_done <= 1'b1;
      if ((b_fire && resp_is_err(m_axi_bresp)) || (r_fire && resp_is_err(m_axi_rresp)))
        rsp_err <= 1'b1;
      if (r_fire && state == ST_RD_RES) rsp_result <= m_axi_rdata;
      if (r_fire && state == ST_RD_OVF) rsp_ovf    <= m_axi_rdata[0];
    end
  end

endmodule

// File: doc/axi_mul_master.md
AXI_MUL_MASTER -- requirements
Module: axi_mul_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AXI data and operand width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning AXI address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning multiplier slave base address.
REQ-004 SHALL have port m_axi_aclk  in  1  the single clock.
REQ-005 SHALL have port m_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  operand pair offered.
REQ-007 SHALL have port cmd_ready  out  1  operand pair accepted.
REQ-008 SHALL have port cmd_a  in  DATA_WIDTH  operand A.
REQ-009 SHALL have port cmd_b  in  DATA_WIDTH  operand B.
REQ-010 SHALL have port rsp_valid  out  1  result available.
REQ-011 SHALL have port rsp_ready  in  1  result consumed.
REQ-012 SHALL have port rsp_result  out  DATA_WIDTH  product low word.
REQ-013 SHALL have port rsp_ovf  out  1  overflow flag.
REQ-014 SHALL have port rsp_err  out  1  any bus error during the job.
REQ-015 SHALL have ports m_axi_awaddr out ADDR_WIDTH, m_axi_awvalid out 1, m_axi_awready in 1, forming the write-address channel.
REQ-016 SHALL have ports m_axi_wdata out DATA_WIDTH, m_axi_wstrb out DATA_WIDTH/8, m_axi_wvalid out 1, m_axi_wready in 1, forming the write-data channel.
REQ-017 SHALL have ports m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1, forming the write-response channel.
REQ-018 SHALL have ports m_axi_araddr out ADDR_WIDTH, m_axi_arvalid out 1, m_axi_arready in 1, forming the read-address channel.
REQ-019 SHALL have ports m_axi_rdata in DATA_WIDTH, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1, forming the read-data channel.

Function
REQ-020 SHALL run FSM IDLE -> WR_A -> WR_B -> RD_RES -> RD_OVF -> RESP -> IDLE; cmd_ready=1 only in IDLE; cmd_a/cmd_b registered on cmd handshake.
REQ-021 SHALL, in WR_A/WR_B, target BASE_ADDR+0x10 (A) and BASE_ADDR+0x14 (B), with wstrb all ones.
REQ-022 SHALL, in WR_A/WR_B, assert awvalid and wvalid together; each drops independently on its own handshake; address/data stay stable until accepted.
REQ-023 SHALL assert bready only after both AW and W have handshaken; advance on bvalid&bready.
REQ-024 SHALL, in RD_RES/RD_OVF, read BASE_ADDR+0x18 and BASE_ADDR+0x1C; hold arvalid until arready; then hold rready until rvalid; advance on the R handshake.
REQ-025 SHALL capture rsp_result from rdata on the 0x18 read, and rsp_ovf from rdata[0] on the 0x1C read.
REQ-026 SHALL treat resp[1]=1 (SLVERR/DECERR) as error; OKAY and EXOKAY are success; errors OR into a sticky rsp_err cleared on the next cmd accept; the sequence still completes.
REQ-027 SHALL hold rsp_valid in RESP until rsp_ready; rsp_* stay stable while rsp_valid=1 and retain their values after the handshake.
REQ-028 SHALL, against a zero-wait slave returning B/R one cycle after the address handshake, assert rsp_valid 9 cycles after the cmd handshake cycle; back-to-back jobs lose no cycle besides RESP->IDLE.
REQ-029 SHALL ignore bvalid/rvalid in states not expecting them; cmd_valid during a job is not accepted.

Reset
REQ-030 SHALL, on m_axi_aresetn=0 (also mid-job), immediately force state IDLE and all valid/ready outputs, rsp_result, rsp_ovf and rsp_err to 0; the aborted job is discarded.

Structure
REQ-031 SHALL keep the FSM state enum and register offsets (0x10/0x14/0x18/0x1C) in a shared package used by the slave as well.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 SHALL cover A=6, B=7 with a zero-wait slave model -> rsp_result=42, ovf=0, err=0, rsp_valid 9 cycles after accept.
REQ-034 SHALL cover A=0xFFFFFFFF, B=2 -> rsp_result=0xFFFFFFFE, ovf=1.
REQ-035 SHALL cover awready delayed 3 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid holds 3, bready rises only after both, result correct.
REQ-036 SHALL cover bresp=2'b10 on the B write -> rsp_err=1, reads still performed; the next job with OKAY responses -> rsp_err=0.
REQ-037 SHALL cover reset asserted during RD_RES -> all outputs 0 at once; after release, a new job A=3, B=5 -> 15.
REQ-038 SHALL cover rsp_ready held low 4 cycles -> rsp_* stable, cmd_ready=0 throughout.
